rv32im_mem_arbiter: RTL and testbench

//  Shares one word-addressed memory port between the instruction fetch unit (IFU, read-only) and the LSU (read/write).

---
 rtl/rv32im_mem_arbiter_if.sv | 50 +++++
 rtl/rv32im_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_rv32im_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32im_mem_arbiter_if.sv
// Memory-arbiter bus: IFU and LSU request ports plus the single RAM port.
// The arbiter binds the slave modport; requesters/RAM bind master.
interface rv32im_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ifu_req_i;
  logic [AW-1:0] ifu_addr_i;
  logic          ifu_ack_o;
  logic [DW-1:0] ifu_rdata_o;
  logic          ifu_err_o;

  logic          lsu_req_i;
  logic [AW-1:0] lsu_addr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic [3:0]    lsu_wmask_i;
  logic          lsu_ack_o;
  logic [DW-1:0] lsu_rdata_o;
  logic          lsu_err_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_wmask_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ready_i;

  modport slave (
    input  ifu_req_i, ifu_addr_i,
    output ifu_ack_o, ifu_rdata_o, ifu_err_o,
    input  lsu_req_i, lsu_addr_i,
    input  lsu_wdata_i, lsu_wmask_i,
    output lsu_ack_o, lsu_rdata_o, lsu_err_o,
    output mem_req_o, mem_we_o, mem_addr_o,
    output mem_wdata_o, mem_wmask_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport master (
    output ifu_req_i, ifu_addr_i,
    input  ifu_ack_o, ifu_rdata_o, ifu_err_o,
    output lsu_req_i, lsu_addr_i,
    output lsu_wdata_i, lsu_wmask_i,
    input  lsu_ack_o, lsu_rdata_o, lsu_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o,
    input  mem_wdata_o, mem_wmask_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/rv32im_mem_arbiter.sv
// IFU/LSU single-port memory arbiter, LSU priority with IFU starvation guard.
// Define MEM_ARB_TIMEOUT_EN to enable the ISSUE-phase timeout with err.
module rv32im_mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  rv32im_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e        state_q;
  logic          own_ifu_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [3:0]    mem_wmask_q;
  logic          ifu_ack_q, lsu_ack_q;
  logic [DW-1:0] ifu_rdata_q, lsu_rdata_q;
  logic [DW-1:0] rdata_d;
  logic          ifu_win, any_req, done, tmo;

  if (STARVE_MAX < 1 || TIMEOUT_CYC < 1) begin : g_cfg_invalid
  end

  assign any_req = bus.ifu_req_i | bus.lsu_req_i;
  assign ifu_win = bus.ifu_req_i &
                   (~bus.lsu_req_i |
                    (starve_q == SW'(STARVE_MAX)));
  assign done    = bus.mem_ready_i | tmo;
  // Writes and timeouts return zero regardless of the RAM bus
  assign rdata_d = (tmo | (|mem_wmask_q)) ? '0
                                          : bus.mem_rdata_i;

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!bus.ifu_req_i || ifu_win) begin
        starve_d = '0;
      end else if (bus.lsu_req_i) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      own_ifu_q   <= 1'b0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      ifu_ack_q   <= 1'b0;
      lsu_ack_q   <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q     <= ISSUE;
            own_ifu_q   <= ifu_win;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= ifu_win ? bus.ifu_addr_i
                                   : bus.lsu_addr_i;
            mem_wdata_q <= ifu_win ? '0 : bus.lsu_wdata_i;
            mem_wmask_q <= ifu_win ? '0 : bus.lsu_wmask_i;
          end
        end
        ISSUE: begin
          if (done) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            mem_wmask_q <= '0;
            if (own_ifu_q) begin
              ifu_ack_q   <= 1'b1;
              ifu_rdata_q <= rdata_d;
            end else begin
              lsu_ack_q   <= 1'b1;
              lsu_rdata_q <= rdata_d;
            end
          end
        end
        RESP: begin
          state_q     <= IDLE;
          ifu_ack_q   <= 1'b0;
          lsu_ack_q   <= 1'b0;
          ifu_rdata_q <= '0;
          lsu_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_q;
  logic          ifu_err_q, lsu_err_q;

  assign tmo = ~bus.mem_ready_i &
               (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q     <= '0;
      ifu_err_q <= 1'b0;
      lsu_err_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == ISSUE) ? tmo_q + 1'b1 : '0;
      if (state_q == ISSUE && done) begin
        ifu_err_q <= own_ifu_q & tmo;
        lsu_err_q <= ~own_ifu_q & tmo;
      end else if (state_q == RESP) begin
        ifu_err_q <= 1'b0;
        lsu_err_q <= 1'b0;
      end
    end
  end

  assign bus.ifu_err_o = ifu_err_q;
  assign bus.lsu_err_o = lsu_err_q;
`else
  assign tmo           = 1'b0;
  assign bus.ifu_err_o = 1'b0;
  assign bus.lsu_err_o = 1'b0;
`endif

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = |mem_wmask_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_wmask_o = mem_wmask_q;
  assign bus.ifu_ack_o   = ifu_ack_q;
  assign bus.ifu_rdata_o = ifu_rdata_q;
  assign bus.lsu_ack_o   = lsu_ack_q;
  assign bus.lsu_rdata_o = lsu_rdata_q;
endmodule

// File: tb/tb_rv32im_mem_arbiter.sv
// Randomised scoreboard bench for rv32im_mem_arbiter.
// Agents and RAM drive on negedge; the monitor checks at posedge+1.
module tb_rv32im_mem_arbiter;
  localparam int TO   = 8;
  localparam int SMAX = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32im_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  rv32im_mem_arbiter #(
    .AW(32), .DW(32), .STARVE_MAX(SMAX), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int nvec = 0;
  int nerr = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void miss(string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: got empty queue want entry", nm);
  endfunction

  req_t        ifu_sq[$], lsu_sq[$];
  logic [31:0] ifu_rq[$], lsu_rq[$];
  logic [31:0] mem[16];

  bit en = 0, b2b = 0, stall = 0;

  // reference model state
  bit   own_ifu, busy, resp;
  req_t cur;
  int   scnt, iss_n;
  int   n_ifu_g = 0, n_lsu_g = 0, n_to = 0, n_ack = 0;

  // IFU / LSU requester agents
  bit ia, la;
  int ig, lg;
  always @(negedge clk) begin
    req_t r;
    if (!rst_n) begin
      bus.ifu_req_i = 0; bus.ifu_addr_i = '0;
      bus.lsu_req_i = 0; bus.lsu_addr_i = '0;
      bus.lsu_wdata_i = '0; bus.lsu_wmask_i = '0;
      ia = 0; la = 0;
      ig = $urandom_range(0, 2); lg = $urandom_range(0, 2);
    end else begin
      if (ia && bus.ifu_ack_o) begin
        ia = 0; bus.ifu_req_i = 0;
        ig = $urandom_range(0, 2);
      end
      if (la && bus.lsu_ack_o) begin
        la = 0; bus.lsu_req_i = 0;
        lg = b2b ? 0 : $urandom_range(0, 2);
      end
      if (!ia && en) begin
        if (ig == 0) begin
          r.addr = $urandom % 16; r.wdata = '0; r.mask = '0;
          bus.ifu_addr_i = r.addr; bus.ifu_req_i = 1;
          ifu_sq.push_back(r); ia = 1;
        end else ig--;
      end
      if (!la && en) begin
        if (lg == 0) begin
          r.addr  = $urandom % 16;
          r.wdata = $urandom;
          r.mask  = ($urandom % 2 == 1) ?
                    4'($urandom_range(1, 15)) : 4'h0;
          bus.lsu_addr_i = r.addr; bus.lsu_wdata_i = r.wdata;
          bus.lsu_wmask_i = r.mask; bus.lsu_req_i = 1;
          lsu_sq.push_back(r); la = 1;
        end else lg--;
      end
    end
  end

  // RAM responder: random wait states, pushes the expected response
  bit mact;
  int mw;
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst_n) begin
      bus.mem_ready_i = 0; bus.mem_rdata_i = '0; mact = 0;
    end else if (bus.mem_req_o) begin
      if (!mact) begin
        mact = 1;
        mw = ($urandom % 4 == 0) ? 3 : $urandom_range(0, 1);
      end
      if (mw == 0 && !stall) begin
        exp = (cur.mask == 0) ? mem[cur.addr[3:0]] : 32'h0;
        if (own_ifu) ifu_rq.push_back(exp);
        else lsu_rq.push_back(exp);
        bus.mem_ready_i = 1;
        bus.mem_rdata_i = bus.mem_we_o ? $urandom
                                       : mem[bus.mem_addr_o[3:0]];
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask_o[b])
            mem[bus.mem_addr_o[3:0]][8*b+:8] =
              bus.mem_wdata_o[8*b+:8];
        mact = 0;
      end else begin
        bus.mem_ready_i = 0; bus.mem_rdata_i = $urandom;
        if (mw > 0) mw--;
      end
    end else begin
      mact = 0;
      bus.mem_ready_i = 1'($urandom % 2);
      bus.mem_rdata_i = $urandom;
    end
  end

  // monitor / scoreboard
  always @(posedge clk) begin : mon
    bit issue, hs, to, grant, exp_i, exp_l, exp_req;
    logic [31:0] e;
    #1;
    if (!rst_n) begin
      ifu_sq.delete(); lsu_sq.delete();
      ifu_rq.delete(); lsu_rq.delete();
      busy = 0; resp = 0; scnt = 0; iss_n = 0;
    end else begin
      issue = busy && !resp;
      hs    = issue && bus.mem_ready_i;
      to    = TO_EN && issue && !bus.mem_ready_i &&
              iss_n == TO;
      grant = !busy && (bus.ifu_req_i || bus.lsu_req_i);
      exp_i = (hs || to) && own_ifu;
      exp_l = (hs || to) && !own_ifu;
      if (exp_i || bus.ifu_ack_o)
        chk("ifu_ack", bus.ifu_ack_o, exp_i);
      if (exp_l || bus.lsu_ack_o)
        chk("lsu_ack", bus.lsu_ack_o, exp_l);
      if (bus.ifu_ack_o) n_ack++;
      if (bus.lsu_ack_o) n_ack++;
      if (exp_i && bus.ifu_ack_o) begin
        if (to) begin
          n_to++;
          chk("ifu_to_rdata", bus.ifu_rdata_o, 0);
          chk("ifu_to_err", bus.ifu_err_o, 1);
        end else if (ifu_rq.size() == 0) miss("ifu_rq");
        else begin
          e = ifu_rq.pop_front();
          chk("ifu_rdata", bus.ifu_rdata_o, e);
          chk("ifu_err", bus.ifu_err_o, 0);
        end
      end
      if (exp_l && bus.lsu_ack_o) begin
        if (to) begin
          n_to++;
          chk("lsu_to_rdata", bus.lsu_rdata_o, 0);
          chk("lsu_to_err", bus.lsu_err_o, 1);
        end else if (lsu_rq.size() == 0) miss("lsu_rq");
        else begin
          e = lsu_rq.pop_front();
          chk("lsu_rdata", bus.lsu_rdata_o, e);
          chk("lsu_err", bus.lsu_err_o, 0);
        end
      end
      if (resp) begin
        busy = 0; resp = 0;
      end else if (hs || to) begin
        resp = 1;
      end else if (grant) begin
        own_ifu = bus.ifu_req_i &&
                  (!bus.lsu_req_i || scnt == SMAX);
        if (own_ifu) begin
          scnt = 0; n_ifu_g++;
          if (ifu_sq.size() == 0) miss("ifu_sq");
          else cur = ifu_sq.pop_front();
        end else begin
          scnt = !bus.ifu_req_i ? 0 :
                 (scnt < SMAX) ? scnt + 1 : SMAX;
          n_lsu_g++;
          if (lsu_sq.size() == 0) miss("lsu_sq");
          else cur = lsu_sq.pop_front();
        end
        busy = 1; iss_n = 1;
      end else if (issue) begin
        iss_n++;
      end
      if (!grant && !bus.ifu_req_i) scnt = 0;
      exp_req = busy && !resp;
      chk("mem_req", bus.mem_req_o, exp_req);
      if (exp_req) begin
        chk("mem_addr", bus.mem_addr_o, cur.addr);
        chk("mem_wmask", bus.mem_wmask_o, cur.mask);
        chk("mem_we", bus.mem_we_o, |cur.mask);
        if (!own_ifu)
          chk("mem_wdata", bus.mem_wdata_o, cur.wdata);
      end
    end
  end

  initial begin
    int k, g0, a0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ctl", {bus.mem_req_o, bus.mem_we_o,
                    bus.mem_wmask_o, bus.ifu_ack_o,
                    bus.lsu_ack_o, bus.ifu_err_o,
                    bus.lsu_err_o}, 0);
    chk("rst_addr", {bus.mem_addr_o, bus.mem_wdata_o}, 0);
    chk("rst_rdata", {bus.ifu_rdata_o, bus.lsu_rdata_o}, 0);
    @(posedge clk);
    #3 rst_n = 1;
    en = 1;
    repeat (400) @(posedge clk);

    b2b = 1;
    g0 = n_ifu_g;
    repeat (240) @(posedge clk);
    chk("starve_ifu_served", n_ifu_g > g0, 1);
    b2b = 0;
    repeat (100) @(posedge clk);

    k = 0;
    do begin
      @(posedge clk); #3; k++;
    end while (!bus.mem_req_o && k < 200);
    chk("rst_wait_issue", bus.mem_req_o, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_ctl", {bus.mem_req_o, bus.mem_we_o,
                        bus.mem_wmask_o, bus.ifu_ack_o,
                        bus.lsu_ack_o, bus.ifu_err_o,
                        bus.lsu_err_o}, 0);
    chk("rst_mid_addr", {bus.mem_addr_o, bus.mem_wdata_o}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    g0 = n_ifu_g + n_lsu_g;
    repeat (300) @(posedge clk);
    chk("post_rst_grants", (n_ifu_g + n_lsu_g) > g0, 1);

    en = 0;
    repeat (30) @(posedge clk);
    #3;
    chk("drain", {bus.ifu_req_i, bus.lsu_req_i,
                  bus.mem_req_o}, 0);
    stall = 1;
    en = 1;
    a0 = n_ack;
    g0 = n_to;
    repeat (40) @(posedge clk);
    #3;
`ifdef MEM_ARB_TIMEOUT_EN
    chk("stall_timeouts", (n_to - g0) > 0, 1);
`else
    chk("stall_no_ack", n_ack - a0, 0);
    chk("stall_req_held", bus.mem_req_o, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
